// File: rtl/chip8_ram_arbiter_pkg.sv
// Shared definitions for the CHIP-8 RAM arbiter: owner ids, RAM geometry and
// the command word that travels from the winning requester to the RAM.
package chip8_ram_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_BLT  = 2'd3;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Round-robin between CPU and blitter: the one that did not own last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] rr_last);
        return (rr_last == OWN_CPU) ? OWN_BLT : OWN_CPU;
    endfunction

endpackage

// File: rtl/chip8_ram_arbiter_rd_tag_pipe.sv
// Owner-tag shift register that follows each accepted read through the RAM
// pipeline and turns the tag leaving the last stage into a per-requester rvalid.
module chip8_ram_arbiter_rd_tag_pipe
    import chip8_ram_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [1:0] i_tag,
    output logic       o_ld_rvalid,
    output logic       o_cpu_rvalid,
    output logic       o_blt_rvalid
);

    logic [1:0] r_tags [DEPTH];

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            for (int i = 0; i < DEPTH; i++) r_tags[i] <= OWN_NONE;
        end else begin
            r_tags[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_tags[i] <= r_tags[i-1];
        end
    end

    assign o_ld_rvalid  = (r_tags[DEPTH-1] == OWN_LD);
    assign o_cpu_rvalid = (r_tags[DEPTH-1] == OWN_CPU);
    assign o_blt_rvalid = (r_tags[DEPTH-1] == OWN_BLT);

endmodule

// File: rtl/chip8_ram_arbiter.sv
// Arbiter sharing the single-port 4 KiB CHIP-8 RAM between loader, CPU and
// blitter, with burst-limited ownership and pipelined read returns.
module chip8_ram_arbiter
    import chip8_ram_arbiter_pkg::*;
#(
    parameter int RAM_LAT   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic              i_ld_req,
    input  logic              i_ld_wr,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic              o_ld_gnt,
    output logic              o_ld_rvalid,
    input  logic              i_cpu_req,
    input  logic              i_cpu_wr,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    input  logic              i_blt_req,
    input  logic [ADDR_W-1:0] i_blt_addr,
    output logic              o_blt_gnt,
    output logic              o_blt_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ram_en,
    output logic              o_ram_wr,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_in,
    input  logic [DATA_W-1:0] i_ram_out,
    output logic [1:0]        o_dbg_state,
    output logic [3:0]        o_dbg_burst
);

    localparam logic [1:0] S_IDLE    = OWN_NONE;
    localparam logic [1:0] S_OWN_LD  = OWN_LD;
    localparam logic [1:0] S_OWN_CPU = OWN_CPU;
    localparam logic [1:0] S_OWN_BLT = OWN_BLT;
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    // Handshake: a transfer happens in the cycle where req && gnt; gnt is
    // combinational, one-hot at most, and the requester must hold wr/addr/wdata
    // stable while req is high and gnt is low.
    logic [1:0]        r_state;
    logic [1:0]        r_rr_last;
    logic [3:0]        r_burst_cnt;
    logic              r_ram_en;
    logic              r_ram_wr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_in;

    logic [3:0]        w_req;
    logic              w_owner_req;
    logic              w_others;
    logic              w_expire;
    logic [1:0]        w_excl;
    logic [3:0]        w_cand;
    logic [1:0]        w_win;
    logic              w_comp;
    logic [3:0]        w_burst_nxt;
    mem_cmd_t          w_cmd;
    logic [1:0]        w_tag;

    // Bit index equals owner id; bit 0 (NONE) never requests.
    assign w_req = {i_blt_req, i_cpu_req, i_ld_req, 1'b0};

    always_comb begin
        w_owner_req = (r_state != S_IDLE) && w_req[r_state];
        w_others    = |(w_req & ~(4'b0001 << r_state));
        w_expire    = w_owner_req && w_others && (r_burst_cnt >= BURST_LIM);
        w_excl      = w_expire ? r_state : S_IDLE;
        w_cand      = w_req & ~(4'b0001 << w_excl);
        w_win       = S_IDLE;
        if (i_res) begin
            w_win = S_IDLE;
        end else if (w_owner_req && !w_expire) begin
            w_win = r_state;
        end else if (w_cand[OWN_LD]) begin
            w_win = S_OWN_LD;
        end else if (w_cand[OWN_CPU] && w_cand[OWN_BLT]) begin
            w_win = rr_pick(r_rr_last);
        end else if (w_cand[OWN_CPU]) begin
            w_win = S_OWN_CPU;
        end else if (w_cand[OWN_BLT]) begin
            w_win = S_OWN_BLT;
        end
        // The accept that hands over ownership already counts toward the new burst.
        w_comp = |(w_req & ~(4'b0001 << w_win));
        if (w_win == S_IDLE || !w_comp) begin
            w_burst_nxt = 4'd0;
        end else if (w_win != r_state) begin
            w_burst_nxt = 4'd1;
        end else begin
            w_burst_nxt = r_burst_cnt + 4'd1;
        end
    end

    always_comb begin
        w_cmd = '0;
        case (w_win)
            S_OWN_LD:  w_cmd = '{wr: i_ld_wr,  addr: i_ld_addr,  wdata: i_ld_wdata};
            S_OWN_CPU: w_cmd = '{wr: i_cpu_wr, addr: i_cpu_addr, wdata: i_cpu_wdata};
            S_OWN_BLT: w_cmd = '{wr: 1'b0,     addr: i_blt_addr, wdata: '0};
            default:   w_cmd = '0;
        endcase
    end

    assign w_tag = (w_win != S_IDLE && !w_cmd.wr) ? w_win : OWN_NONE;

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= 4'd0;
            r_rr_last   <= OWN_CPU;
            r_ram_en    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_in    <= '0;
        end else begin
            r_state     <= w_win;
            r_burst_cnt <= w_burst_nxt;
            if (w_win == S_OWN_CPU || w_win == S_OWN_BLT) r_rr_last <= w_win;
            r_ram_en <= (w_win != S_IDLE);
            r_ram_wr <= (w_win != S_IDLE) && w_cmd.wr;
            if (w_win != S_IDLE) begin
                r_ram_addr <= w_cmd.addr;
                r_ram_in   <= w_cmd.wdata;
            end
        end
    end

    chip8_ram_arbiter_rd_tag_pipe #(
        .DEPTH (1 + RAM_LAT)
    ) u_tag_pipe (
        .i_clk        (i_clk),
        .i_res        (i_res),
        .i_tag        (w_tag),
        .o_ld_rvalid  (o_ld_rvalid),
        .o_cpu_rvalid (o_cpu_rvalid),
        .o_blt_rvalid (o_blt_rvalid)
    );

    assign o_ld_gnt    = (w_win == S_OWN_LD);
    assign o_cpu_gnt   = (w_win == S_OWN_CPU);
    assign o_blt_gnt   = (w_win == S_OWN_BLT);
    assign o_rdata     = i_ram_out;
    assign o_ram_en    = r_ram_en;
    assign o_ram_wr    = r_ram_wr;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_in    = r_ram_in;
    assign o_dbg_state = r_state;
    assign o_dbg_burst = r_burst_cnt;

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Bench for chip8_ram_arbiter: behavioural RAM, a rule-level arbitration model
// and an in-order read scoreboard, driven by directed and random steps.
module tb_chip8_ram_arbiter;

    localparam int LAT = 1;
    localparam int MB  = 8;
    localparam int W   = 26;

    logic        clk = 1'b0;
    logic        res;
    logic        ld_req, ld_wr, cpu_req, cpu_wr, blt_req;
    logic [11:0] ld_addr, cpu_addr, blt_addr;
    logic [7:0]  ld_wdata, cpu_wdata;
    logic        ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, blt_gnt, blt_rvalid;
    logic [7:0]  rdata, ram_in, ram_out;
    logic        ram_en, ram_wr;
    logic [11:0] ram_addr;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_burst;

    always #5 clk = ~clk;

    chip8_ram_arbiter #(.RAM_LAT(LAT), .MAX_BURST(MB)) dut (
        .i_clk(clk), .i_res(res),
        .i_ld_req(ld_req), .i_ld_wr(ld_wr), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
        .o_ld_gnt(ld_gnt), .o_ld_rvalid(ld_rvalid),
        .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid),
        .i_blt_req(blt_req), .i_blt_addr(blt_addr),
        .o_blt_gnt(blt_gnt), .o_blt_rvalid(blt_rvalid),
        .o_rdata(rdata), .o_ram_en(ram_en), .o_ram_wr(ram_wr), .o_ram_addr(ram_addr),
        .o_ram_in(ram_in), .i_ram_out(ram_out),
        .o_dbg_state(dbg_state), .o_dbg_burst(dbg_burst)
    );

    function automatic logic [7:0] init_val(input int a);
        case (a)
            12'h200: return 8'hA2;
            12'h050: return 8'hF0;
            12'h051: return 8'h90;
            12'h052: return 8'h90;
            12'h053: return 8'hF0;
            default: return 8'(a * 37 + 11);
        endcase
    endfunction

    // Behavioural RAM macro with LAT-cycle synchronous read.
    logic [7:0] mem [4096];
    logic [7:0] rd_pipe [LAT];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (ram_en && ram_wr) mem[ram_addr] <= ram_in;
            rd_pipe[0] <= mem[ram_addr];
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign ram_out = rd_pipe[LAT-1];

    // Reference model state
    logic [7:0]   ref_mem [4096];
    logic [W-1:0] exp_q [$];
    int           m_owner, m_cnt, m_rr;
    logic         e_en, e_wr;
    logic [11:0]  e_addr;
    logic [7:0]   e_in;
    int           cyc, last_w, obs_w;
    int           checks, errors;
    int           seq [40];
    int           rl, ri, cnt, n_cpu_rv;
    logic [7:0]   got;
    logic [7:0]   got_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic req_of(input int k);
        case (k)
            1: return ld_req;
            2: return cpu_req;
            3: return blt_req;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic wr_of(input int k);
        return (k == 1) ? ld_wr : (k == 2) ? cpu_wr : 1'b0;
    endfunction

    function automatic logic [11:0] addr_of(input int k);
        return (k == 1) ? ld_addr : (k == 2) ? cpu_addr : blt_addr;
    endfunction

    function automatic logic [7:0] wdata_of(input int k);
        return (k == 1) ? ld_wdata : (k == 2) ? cpu_wdata : 8'h00;
    endfunction

    function automatic logic contested(input int k);
        logic c;
        c = 1'b0;
        for (int j = 1; j <= 3; j++) if (j != k && req_of(j)) c = 1'b1;
        return c;
    endfunction

    // Who should receive gnt this cycle, from the ownership/burst/round-robin rules.
    function automatic int pick_winner();
        logic keeps;
        int   excl;
        keeps = (m_owner != 0) && req_of(m_owner);
        if (keeps && !(contested(m_owner) && m_cnt >= MB)) return m_owner;
        excl = keeps ? m_owner : 0;
        if (req_of(1) && excl != 1) return 1;
        if (req_of(2) && excl != 2 && req_of(3) && excl != 3) return (m_rr == 2) ? 3 : 2;
        if (req_of(2) && excl != 2) return 2;
        if (req_of(3) && excl != 3) return 3;
        return 0;
    endfunction

    task automatic set_req(input int k, input logic rq, input logic wr,
                           input logic [11:0] a, input logic [7:0] d);
        case (k)
            1: begin ld_req = rq; ld_wr = wr; ld_addr = a; ld_wdata = d; end
            2: begin cpu_req = rq; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; end
            default: begin blt_req = rq; blt_addr = a; end
        endcase
    endtask

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_rr = 2; last_w = 0;
        e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_in = '0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'({ld_gnt, cpu_gnt, blt_gnt}), 32'd0);
        check({tag, "_rvalid"}, 32'({ld_rvalid, cpu_rvalid, blt_rvalid}), 32'd0);
        check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        check({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_in"}, 32'(ram_in), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_burst"}, 32'(dbg_burst), 32'd0);
    endtask

    // One clock cycle: compare at the falling edge, then commit the model.
    task automatic step();
        int           w, exp_owner;
        logic [W-1:0] head;
        @(negedge clk);
        w = pick_winner();
        obs_w = ld_gnt ? 1 : cpu_gnt ? 2 : blt_gnt ? 3 : 0;
        check("ld_gnt", 32'(ld_gnt), 32'(w == 1));
        check("cpu_gnt", 32'(cpu_gnt), 32'(w == 2));
        check("blt_gnt", 32'(blt_gnt), 32'(w == 3));
        check("ram_en", 32'(ram_en), 32'(e_en));
        check("ram_wr", 32'(ram_wr), 32'(e_wr));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        check("ram_in", 32'(ram_in), 32'(e_in));
        check("state", 32'(dbg_state), 32'(m_owner));
        check("burst", 32'(dbg_burst), 32'(m_cnt));
        exp_owner = 0;
        if (exp_q.size() > 0 && int'(exp_q[0][25:10]) == cyc) begin
            head = exp_q.pop_front();
            exp_owner = int'(head[9:8]);
            check("rdata", 32'(rdata), 32'(head[7:0]));
        end
        check("ld_rvalid", 32'(ld_rvalid), 32'(exp_owner == 1));
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_owner == 2));
        check("blt_rvalid", 32'(blt_rvalid), 32'(exp_owner == 3));
        if (w != 0) begin
            e_en = 1'b1;
            e_wr = wr_of(w);
            e_addr = addr_of(w);
            e_in = wdata_of(w);
            if (e_wr) ref_mem[e_addr] = e_in;
            else exp_q.push_back({16'(cyc + 1 + LAT), 2'(w), ref_mem[e_addr]});
            if (!contested(w)) m_cnt = 0;
            else if (w != m_owner) m_cnt = 1;
            else m_cnt = m_cnt + 1;
            if (w >= 2) m_rr = w;
        end else begin
            e_en = 1'b0;
            e_wr = 1'b0;
            m_cnt = 0;
        end
        m_owner = w;
        last_w = w;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_random();
        for (int k = 1; k <= 3; k++) begin
            if (!(req_of(k) && last_w != k))
                set_req(k, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                        12'h300 | 12'($urandom_range(0, 15)), 8'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        for (int k = 1; k <= 3; k++) set_req(k, 1'b0, 1'b0, 12'h000, 8'h00);
        res = 1'b0;
        model_reset();
        #2 res = 1'b1;
        #1 check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1 res = 1'b0;

        // Single CPU read of 0x200
        set_req(2, 1'b1, 1'b0, 12'h200, 8'h00);
        step();
        check("p1_cpu_gnt_c0", 32'(obs_w), 32'd2);
        set_req(2, 1'b0, 1'b0, 12'h200, 8'h00);
        check("p1_ram_en_c1", 32'(ram_en), 32'd1);
        check("p1_ram_addr_c1", 32'(ram_addr), 32'h200);
        step();
        check("p1_cpu_rvalid_c2", 32'(cpu_rvalid), 32'd1);
        check("p1_rdata_c2", 32'(rdata), 32'hA2);
        step();
        check("p1_cpu_rvalid_c3", 32'(cpu_rvalid), 32'd0);
        repeat (2) step();

        // CPU and blitter contending continuously: 8/8 alternation
        set_req(2, 1'b1, 1'b0, 12'($urandom_range(0, 4095)), 8'h00);
        step();
        set_req(3, 1'b1, 1'b0, 12'($urandom_range(0, 4095)), 8'h00);
        for (int i = 0; i < 40; i++) begin
            step();
            seq[i] = obs_w;
            if (last_w == 2) set_req(2, 1'b1, 1'b0, 12'($urandom_range(0, 4095)), 8'h00);
            if (last_w == 3) set_req(3, 1'b1, 1'b0, 12'($urandom_range(0, 4095)), 8'h00);
        end
        rl = 1; ri = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i < 40 && seq[i] == seq[i-1]) rl++;
            else begin
                check("p2_run_len", 32'(rl), 32'd8);
                check("p2_run_owner", 32'(seq[i-1]), (ri % 2 == 0) ? 32'd2 : 32'd3);
                ri++;
                rl = 1;
            end
        end
        check("p2_run_count", 32'(ri), 32'd5);
        set_req(2, 1'b0, 1'b0, 12'h000, 8'h00);
        set_req(3, 1'b0, 1'b0, 12'h000, 8'h00);
        repeat (3) step();

        // Loader joins a CPU lock, writes 0x5A to 0x300, CPU then reads 0x300
        set_req(2, 1'b1, 1'b0, 12'h100, 8'h00);
        step();
        set_req(1, 1'b1, 1'b1, 12'h300, 8'h5A);
        set_req(2, 1'b1, 1'b0, 12'h101, 8'h00);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_w == 2) cnt++;
            set_req(2, 1'b1, 1'b0, (i == 7) ? 12'h300 : 12'(12'h102 + i), 8'h00);
        end
        check("p3_cpu_accepts", 32'(cnt), 32'd8);
        step();
        check("p3_ld_gnt", 32'(obs_w), 32'd1);
        set_req(1, 1'b0, 1'b0, 12'h000, 8'h00);
        step();
        check("p3_cpu_regain", 32'(obs_w), 32'd2);
        set_req(2, 1'b0, 1'b0, 12'h000, 8'h00);
        got = 8'h00;
        repeat (4) begin
            step();
            if (cpu_rvalid) got = rdata;
        end
        check("p3_cpu_rdata_300", 32'(got), 32'h5A);

        // Back-to-back blitter reads of 0x050..0x053
        got_q.delete();
        n_cpu_rv = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) set_req(3, 1'b1, 1'b0, 12'(12'h050 + i), 8'h00);
            else set_req(3, 1'b0, 1'b0, 12'h000, 8'h00);
            step();
            if (blt_rvalid) got_q.push_back(rdata);
            if (cpu_rvalid) n_cpu_rv++;
        end
        check("p4_blt_rvalid_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("p4_data0", 32'(got_q[0]), 32'hF0);
            check("p4_data1", 32'(got_q[1]), 32'h90);
            check("p4_data2", 32'(got_q[2]), 32'h90);
            check("p4_data3", 32'(got_q[3]), 32'hF0);
        end
        check("p4_no_cpu_rvalid", 32'(n_cpu_rv), 32'd0);

        // Randomised traffic on a small address window
        repeat (400) begin
            drive_random();
            step();
        end
        for (int k = 1; k <= 3; k++) set_req(k, 1'b0, 1'b0, 12'h000, 8'h00);
        repeat (4) step();

        // Reset one cycle after an accepted CPU read
        set_req(2, 1'b1, 1'b0, 12'h123, 8'h00);
        step();
        set_req(2, 1'b0, 1'b0, 12'h000, 8'h00);
        res = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        check_reset_outputs("rst_mid_hold");
        @(posedge clk);
        #1 res = 1'b0;
        model_reset();
        repeat (4) step();
        set_req(2, 1'b1, 1'b0, 12'h200, 8'h00);
        step();
        check("p6_gnt_from_idle", 32'(obs_w), 32'd2);
        set_req(2, 1'b0, 1'b0, 12'h000, 8'h00);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
